// File: rtl/hdr_pkg.sv
// rtl/hdr_pkg.sv - shared states and constants for the HDR dispatch engine
package hdr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CCC,
    ST_DUMMY,
    ST_PAYLOAD,
    ST_EXIT
  } hdr_state_e;

  localparam logic [2:0]  HDR_MODE   = 3'd6;
  localparam logic [11:0] ADDR_IDLE  = 12'd1000;
  localparam logic [11:0] ADDR_DUMMY = 12'd450;

  localparam int ENG_CCC = 0;
  localparam int ENG_DDR = 1;

endpackage

// File: rtl/hdr_dispatch_engine_if.sv
// rtl/hdr_dispatch_engine_if.sv - command descriptor handshake into the HDR dispatch engine
interface hdr_dispatch_engine_if #(
  parameter int NUM_ENG = 2
);

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_cp;
  logic                       cmd_toc;
  logic [$clog2(NUM_ENG)-1:0] cmd_eng;

  modport master (
    output cmd_valid, cmd_cp, cmd_toc, cmd_eng,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_cp, cmd_toc, cmd_eng,
    output cmd_ready
  );

endinterface

// File: rtl/hdr_cmd_fifo.sv
// rtl/hdr_cmd_fifo.sv - synchronous descriptor FIFO with flush, full/empty and occupancy count
module hdr_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     i_sys_clk,
  input  logic                     i_sys_rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop frees the head slot in the same cycle, so a full FIFO may still accept
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge i_sys_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/hdr_dispatch_engine.sv
// rtl/hdr_dispatch_engine.sv - sequences buffered HDR descriptors across CCC/payload sub-engines with watchdog
module hdr_dispatch_engine #(
  parameter int          NUM_ENG    = 2,
  parameter int          CMD_DEPTH  = 4,
  parameter int          TMO_CYCLES = 4096,
  parameter logic [11:0] ADDR_IDLE  = hdr_pkg::ADDR_IDLE,
  parameter logic [11:0] ADDR_DUMMY = hdr_pkg::ADDR_DUMMY,
  parameter logic [2:0]  HDR_MODE   = hdr_pkg::HDR_MODE
) (
  input  logic                       i_sys_clk,
  input  logic                       i_sys_rst_n,
  input  logic                       i_hdr_en,
  input  logic [2:0]                 i_mode,
  hdr_dispatch_engine_if.slave       cmd,
  output logic [NUM_ENG-1:0]         o_eng_en,
  input  logic [NUM_ENG-1:0]         i_eng_done,
  output logic [$clog2(NUM_ENG)-1:0] o_mux_sel,
  output logic [11:0]                o_regf_addr_special,
  output logic                       o_hdr_done,
  output logic                       o_hdr_err,
  output logic                       o_busy
);

  import hdr_pkg::*;

  localparam int ENG_W = $clog2(NUM_ENG);
  localparam int WD_W  = $clog2(TMO_CYCLES);
  localparam int FW    = 2 + ENG_W;

  hdr_state_e           state;
  logic                 cur_toc;
  logic [ENG_W-1:0]     cur_eng;
  logic                 last_was_ccc;
  logic                 waiting;
  logic [WD_W-1:0]      wdog;

  logic                 fifo_full, fifo_empty;
  logic [$clog2(CMD_DEPTH):0] fifo_count;
  logic [FW-1:0]        fifo_dout;
  logic                 head_cp, head_toc;
  logic [ENG_W-1:0]     head_eng;
  logic                 push, pop, flush;
  logic                 bad_eng, mode_hdr, have_next, eng_done, wdog_hit;

  assign cmd.cmd_ready = !fifo_full;
  assign push  = cmd.cmd_valid && !fifo_full;
  assign pop   = (state == ST_FETCH);
  assign flush = (state != ST_IDLE) && !i_hdr_en;

  hdr_cmd_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(FW)) u_fifo (
    .i_sys_clk   (i_sys_clk),
    .i_sys_rst_n (i_sys_rst_n),
    .flush       (flush),
    .push        (push),
    .din         ({cmd.cmd_cp, cmd.cmd_toc, cmd.cmd_eng}),
    .pop         (pop),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count)
  );

  assign {head_cp, head_toc, head_eng} = fifo_dout;
  assign bad_eng   = !head_cp && ((int'(head_eng) == ENG_CCC) || (int'(head_eng) >= NUM_ENG));
  assign mode_hdr  = (i_mode == HDR_MODE);
  assign have_next = (fifo_count != '0);
  assign wdog_hit  = (wdog == WD_W'(TMO_CYCLES - 1));
  // CCC and DUMMY both run on engine 0; only PAYLOAD listens to the selected engine
  assign eng_done  = (state == ST_PAYLOAD) ? i_eng_done[cur_eng] : i_eng_done[ENG_CCC];

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state <= ST_IDLE;  cur_toc <= 1'b0;  cur_eng <= '0;
      last_was_ccc <= 1'b0;  waiting <= 1'b0;  wdog <= '0;
      o_eng_en <= '0;  o_mux_sel <= '0;  o_regf_addr_special <= ADDR_IDLE;
      o_hdr_done <= 1'b0;  o_hdr_err <= 1'b0;  o_busy <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;  last_was_ccc <= 1'b0;  waiting <= 1'b0;  wdog <= '0;
      o_eng_en <= '0;  o_mux_sel <= '0;  o_regf_addr_special <= ADDR_IDLE;
      o_hdr_done <= 1'b0;  o_hdr_err <= 1'b0;  o_busy <= 1'b0;
    end else begin
      o_hdr_done <= 1'b0;
      o_hdr_err  <= 1'b0;
      if (|o_eng_en) wdog <= wdog + WD_W'(1);
      case (state)
        ST_IDLE: if (i_hdr_en && !fifo_empty) begin
          state <= ST_FETCH;  o_busy <= 1'b1;  wdog <= '0;
        end
        ST_FETCH: begin
          cur_toc <= head_toc;  cur_eng <= head_eng;  wdog <= '0;
          if (head_cp) begin
            state <= ST_CCC;  o_eng_en <= NUM_ENG'(1);  o_mux_sel <= ENG_W'(ENG_CCC);
          end else if (bad_eng) begin
            state <= ST_EXIT;  o_hdr_done <= 1'b1;  o_hdr_err <= 1'b1;
          end else if (last_was_ccc) begin
            state <= ST_DUMMY;  o_eng_en <= NUM_ENG'(1);  o_mux_sel <= ENG_W'(ENG_CCC);
            o_regf_addr_special <= ADDR_DUMMY;
          end else begin
            state <= ST_PAYLOAD;  o_eng_en <= NUM_ENG'(1) << head_eng;  o_mux_sel <= head_eng;
          end
        end
        ST_CCC, ST_PAYLOAD: begin
          if (waiting) begin
            if (!mode_hdr) begin
              state <= ST_EXIT;  o_hdr_done <= 1'b1;  waiting <= 1'b0;  wdog <= '0;
            end else if (have_next) begin
              state <= ST_FETCH;  waiting <= 1'b0;  wdog <= '0;
            end
          end else if (eng_done) begin
            o_eng_en <= '0;
            last_was_ccc <= (state == ST_CCC);
            if (cur_toc || !mode_hdr) begin
              state <= ST_EXIT;  o_hdr_done <= 1'b1;  wdog <= '0;
            end else if (have_next) begin
              state <= ST_FETCH;  wdog <= '0;
            end else begin
              waiting <= 1'b1;
            end
          end else if (wdog_hit) begin
            state <= ST_EXIT;  o_eng_en <= '0;  o_hdr_done <= 1'b1;  o_hdr_err <= 1'b1;  wdog <= '0;
          end
        end
        ST_DUMMY: begin
          if (eng_done) begin
            state <= ST_PAYLOAD;  last_was_ccc <= 1'b0;  wdog <= '0;
            o_regf_addr_special <= ADDR_IDLE;
            o_eng_en <= NUM_ENG'(1) << cur_eng;  o_mux_sel <= cur_eng;
          end else if (wdog_hit) begin
            state <= ST_EXIT;  o_eng_en <= '0;  o_regf_addr_special <= ADDR_IDLE;
            o_hdr_done <= 1'b1;  o_hdr_err <= 1'b1;  wdog <= '0;
          end
        end
        ST_EXIT: begin
          state <= ST_IDLE;  last_was_ccc <= 1'b0;  o_busy <= 1'b0;  o_mux_sel <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdr_dispatch_engine.sv
// tb/tb_hdr_dispatch_engine.sv - directed self-checking bench for hdr_dispatch_engine
module tb_hdr_dispatch_engine;
  import hdr_pkg::*;

  localparam logic DDR = 1'(ENG_DDR);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hdr_en = 1'b0;
  logic [2:0]  mode = 3'd6;
  logic [1:0]  eng_done = 2'b00;
  logic [1:0]  eng_en;
  logic        mux_sel;
  logic [11:0] addr;
  logic        hdr_done, hdr_err, busy;
  int          passes = 0;
  int          fails = 0;
  int          total = 0;

  hdr_dispatch_engine_if #(.NUM_ENG(2)) cmd_if();

  always #5 clk = ~clk;

  hdr_dispatch_engine dut (
    .i_sys_clk           (clk),
    .i_sys_rst_n         (rst_n),
    .i_hdr_en            (hdr_en),
    .i_mode              (mode),
    .cmd                 (cmd_if),
    .o_eng_en            (eng_en),
    .i_eng_done          (eng_done),
    .o_mux_sel           (mux_sel),
    .o_regf_addr_special (addr),
    .o_hdr_done          (hdr_done),
    .o_hdr_err           (hdr_err),
    .o_busy              (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic cp, input logic toc, input logic eng);
    int n = 0;
    while (!cmd_if.cmd_ready && n < 20) begin tick(); n++; end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_cp    = cp;
    cmd_if.cmd_toc   = toc;
    cmd_if.cmd_eng   = eng;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_en;
    int n = 0;
    while (eng_en == 2'b00 && n < 50) begin tick(); n++; end
  endtask

  // run one engine step: done pulse on the n-th enabled cycle
  task automatic run_eng(input string tag, input logic [1:0] exp_en, input logic exp_mux,
                         input logic [11:0] exp_addr, input int n);
    int hi = 0;
    wait_en();
    check({tag, "_en"}, eng_en, exp_en);
    check({tag, "_mux"}, mux_sel, exp_mux);
    check({tag, "_addr"}, addr, exp_addr);
    for (int i = 1; i <= n; i++) begin
      if (eng_en == exp_en) hi++;
      if (i == n) eng_done = exp_en;
      tick();
    end
    eng_done = 2'b00;
    check({tag, "_en_cycles"}, hi, n);
  endtask

  initial begin
    int cnt;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_cp    = 1'b0;
    cmd_if.cmd_toc   = 1'b0;
    cmd_if.cmd_eng   = 1'b0;
    tick(); tick(); tick();
    check("rst_en", eng_en, 0);
    check("rst_addr", addr, 1000);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", hdr_done, 0);
    check("rst_mux", mux_sel, 0);
    rst_n = 1'b1;
    hdr_en = 1'b1;
    tick();

    // single CCC with toc
    push(1'b1, 1'b1, 1'b0);
    run_eng("t1_ccc", 2'b01, 1'b0, 12'd1000, 5);
    check("t1_en_off", eng_en, 0);
    check("t1_done", hdr_done, 1);
    check("t1_err", hdr_err, 0);
    tick();
    check("t1_done_pulse", hdr_done, 0);
    check("t1_idle", busy, 0);

    // CCC followed by payload inserts a dummy CCC
    push(1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b1, DDR);
    run_eng("t2_ccc", 2'b01, 1'b0, 12'd1000, 3);
    run_eng("t2_dummy", 2'b01, 1'b0, 12'd450, 2);
    run_eng("t2_pay", 2'b10, 1'b1, 12'd1000, 2);
    check("t2_done", hdr_done, 1);
    check("t2_err", hdr_err, 0);
    tick();

    // four back-to-back DDR runs, FIFO full beforehand
    hdr_en = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, (i == 3), DDR);
    check("t3_ready_full", cmd_if.cmd_ready, 0);
    check("t3_hold_idle", busy, 0);
    hdr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_eng("t3_pay", 2'b10, 1'b1, 12'd1000, 2);
      if (i == 0) check("t3_ready_again", cmd_if.cmd_ready, 1);
      if (i < 3) begin
        check("t3_busy", busy, 1);
        check("t3_no_done", hdr_done, 0);
      end
    end
    check("t3_done", hdr_done, 1);
    tick();

    // watchdog timeout
    push(1'b0, 1'b1, DDR);
    wait_en();
    cnt = 0;
    while (eng_en != 2'b00 && cnt < 5000) begin cnt++; tick(); end
    check("t4_tmo_cycles", cnt, 4096);
    check("t4_tmo_done", hdr_done, 1);
    check("t4_tmo_err", hdr_err, 1);
    check("t4_tmo_en", eng_en, 0);
    tick();

    // done on the limit cycle wins over timeout
    push(1'b0, 1'b1, DDR);
    wait_en();
    for (int i = 1; i < 4096; i++) tick();
    eng_done = 2'b10;
    tick();
    eng_done = 2'b00;
    check("t4_edge_done", hdr_done, 1);
    check("t4_edge_err", hdr_err, 0);
    check("t4_edge_en", eng_en, 0);
    tick();

    // mode change while waiting on an empty FIFO
    push(1'b0, 1'b0, DDR);
    run_eng("t5_pay", 2'b10, 1'b1, 12'd1000, 2);
    check("t5_wait_en", eng_en, 0);
    check("t5_wait_busy", busy, 1);
    check("t5_wait_nodone", hdr_done, 0);
    tick();
    mode = 3'd3;
    tick();
    check("t5_mode_done", hdr_done, 1);
    check("t5_mode_err", hdr_err, 0);
    mode = 3'd6;
    tick();

    // abort mid-CCC flushes the queued descriptor
    push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b0);
    wait_en();
    check("t5_abort_pre", eng_en, 2'b01);
    hdr_en = 1'b0;
    tick();
    check("t5_abort_busy", busy, 0);
    check("t5_abort_en", eng_en, 0);
    check("t5_abort_nodone", hdr_done, 0);
    hdr_en = 1'b1;
    tick(); tick();
    check("t5_abort_flushed", busy, 0);

    // async reset in the middle of DUMMY
    push(1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b1, DDR);
    run_eng("t6_ccc", 2'b01, 1'b0, 12'd1000, 2);
    wait_en();
    check("t6_in_dummy", addr, 450);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_addr", addr, 1000);
    check("t6_rst_en", eng_en, 0);
    check("t6_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("t6_post_rst_idle", busy, 0);

    // payload descriptor naming engine 0 is rejected
    push(1'b0, 1'b1, 1'b0);
    cnt = 0;
    while (!hdr_done && cnt < 20) begin tick(); cnt++; end
    check("t6_bad_done", hdr_done, 1);
    check("t6_bad_err", hdr_err, 1);
    check("t6_bad_en", eng_en, 0);
    tick();
    check("t6_bad_idle", busy, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
